// File: rtl/store_packer_pkg.sv
// Command/response types shared by the AXI-lite store packer and unpacker.
package store_packer_pkg;

  localparam int packed_cmd_width_gp  = 32;
  localparam int packed_addr_width_gp = 23;
  localparam int packed_data_width_gp = 8;

  typedef struct packed {
    logic                            w_not_r;
    logic [packed_addr_width_gp-1:0] addr;
    logic [packed_data_width_gp-1:0] data;
  } packed_store_cmd_s;

  // Any set address bit at or above the implemented width puts the command out of range.
  function automatic logic addr_in_range(input logic [packed_addr_width_gp-1:0] addr,
                                         input int                             width);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < packed_addr_width_gp; i++) begin
      if (i >= width && addr[i]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with synchronous active-high clear; holds its value while en_i is low.
module bsg_dff_reset_en #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i)   data_q <= '0;
    else if (en_i) data_q <= data_i;
  end

  assign data_o = data_q;

endmodule

// File: rtl/store_unpacker.sv
// Executes packed store commands as single byte accesses; cmd->mem_v_o 1 cycle, mem_v_i->v_o 1 cycle, one cmd in flight.
// Stalls upstream via ready_o=0 while busy; mem and response outputs hold until accepted. STORE_UNPACKER_WRITE_ACK_EN echoes writes.
module store_unpacker
  import store_packer_pkg::*;
#(
  parameter int mem_addr_width_p = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [31:0]                 data_i,
  input  logic                        v_i,
  output logic                        ready_o,
  output logic [31:0]                 data_o,
  output logic                        v_o,
  input  logic                        ready_i,
  output logic                        mem_v_o,
  output logic                        mem_w_o,
  output logic [mem_addr_width_p-1:0] mem_addr_o,
  output logic [7:0]                  mem_data_o,
  input  logic                        mem_ready_i,
  input  logic [7:0]                  mem_data_i,
  input  logic                        mem_v_i
);

  typedef enum logic [1:0] {e_idle, e_mem, e_wait, e_resp} state_e;

`ifdef STORE_UNPACKER_WRITE_ACK_EN
  localparam bit write_ack_lp = 1'b1;
`else
  localparam bit write_ack_lp = 1'b0;
`endif

  state_e            state_q, state_d;
  packed_store_cmd_s cmd_in, cmd_q;
  logic              cmd_hs, in_range;
  logic              rdata_en;
  logic [7:0]        rdata_d, rdata_q;
  logic              cmd_addr_unused;

  assign cmd_in   = packed_store_cmd_s'(data_i);
  assign cmd_hs   = v_i & ready_o;
  assign in_range = addr_in_range(cmd_in.addr, mem_addr_width_p);

  bsg_dff_reset_en #(.width_p(packed_cmd_width_gp)) cmd_reg (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (cmd_hs),
    .data_i (cmd_in),
    .data_o (cmd_q)
  );

  bsg_dff_reset_en #(.width_p(packed_data_width_gp)) rdata_reg (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (rdata_en),
    .data_i (rdata_d),
    .data_o (rdata_q)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= e_idle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    rdata_en = 1'b0;
    rdata_d  = mem_data_i;
    case (state_q)
      e_idle: begin
        if (cmd_hs) begin
          if (in_range) begin
            state_d = e_mem;
          end else if (!cmd_in.w_not_r) begin
            // Out-of-range reads complete locally with all-ones data.
            rdata_en = 1'b1;
            rdata_d  = 8'hFF;
            state_d  = e_resp;
          end else begin
            state_d = write_ack_lp ? e_resp : e_idle;
          end
        end
      end
      e_mem: begin
        if (mem_ready_i) begin
          if (cmd_q.w_not_r) state_d = write_ack_lp ? e_resp : e_idle;
          else               state_d = e_wait;
        end
      end
      e_wait: begin
        if (mem_v_i) begin
          rdata_en = 1'b1;
          state_d  = e_resp;
        end
      end
      e_resp: begin
        if (ready_i) state_d = e_idle;
      end
      default: state_d = e_idle;
    endcase
  end

  assign ready_o    = (state_q == e_idle);
  assign v_o        = (state_q == e_resp);
  assign mem_v_o    = (state_q == e_mem);
  assign mem_w_o    = cmd_q.w_not_r;
  assign mem_addr_o = cmd_q.addr[mem_addr_width_p-1:0];
  assign mem_data_o = cmd_q.data;

  always_comb begin
    data_o = '0;
    if (state_q == e_resp) begin
`ifdef STORE_UNPACKER_WRITE_ACK_EN
      data_o = cmd_q.w_not_r ? 32'(cmd_q) : {24'b0, rdata_q};
`else
      data_o = {24'b0, rdata_q};
`endif
    end
  end

  // Upper address bits only feed the range check on the incoming command.
  assign cmd_addr_unused = ^cmd_q.addr;

endmodule

// File: tb/tb_store_unpacker.sv
// Scoreboarded bench for store_unpacker with a scripted memory responder (mem_addr_width_p=16).
module tb_store_unpacker;

  logic        clk_i = 1'b0;
  logic        reset_i, v_i, ready_o, v_o, ready_i;
  logic [31:0] data_i, data_o;
  logic        mem_v_o, mem_w_o, mem_ready_i, mem_v_i;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_data_o, mem_data_i;

  int          assert_cnt = 0;
  int          fail_cnt   = 0;
  int          mem_hs_cnt = 0;
  logic [31:0] exp_q[$];

  store_unpacker #(.mem_addr_width_p(16)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .data_i     (data_i),
    .v_i        (v_i),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .v_o        (v_o),
    .ready_i    (ready_i),
    .mem_v_o    (mem_v_o),
    .mem_w_o    (mem_w_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_ready_i(mem_ready_i),
    .mem_data_i (mem_data_i),
    .mem_v_i    (mem_v_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Response scoreboard and memory handshake counter, sampled away from the active edge.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (mem_v_o && mem_ready_i) mem_hs_cnt++;
      if (v_o && ready_i) begin
        if (exp_q.size() == 0) chk("unexpected_resp", {31'b0, v_o}, 32'd0);
        else                   chk("resp_data", data_o, exp_q.pop_front());
      end
    end
  end

  task automatic send_cmd(input logic [31:0] cmd, input logic exp_mem);
    int n = 0;
    while (!ready_o && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("ready_o_before_cmd", {31'b0, ready_o}, 32'd1);
    data_i = cmd;
    v_i    = 1'b1;
    if (!exp_mem && !cmd[31]) exp_q.push_back(32'h0000_00FF);
`ifdef STORE_UNPACKER_WRITE_ACK_EN
    if (cmd[31]) exp_q.push_back(cmd);
`endif
    @(posedge clk_i); #1;
    v_i = 1'b0;
    @(negedge clk_i);
    chk("mem_v_o_next", {31'b0, mem_v_o}, {31'b0, exp_mem});
    if (exp_mem) chk("ready_o_busy", {31'b0, ready_o}, 32'd0);
  endtask

  task automatic serve_mem(input logic w, input logic [15:0] addr, input logic [7:0] wdata,
                           input logic [7:0] rdata, input int stall, input int lat);
    int n = 0;
    while (!mem_v_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("mem_v_o_seen", {31'b0, mem_v_o}, 32'd1);
    chk("mem_w_o", {31'b0, mem_w_o}, {31'b0, w});
    chk("mem_addr_o", {16'b0, mem_addr_o}, {16'b0, addr});
    chk("mem_data_o", {24'b0, mem_data_o}, {24'b0, wdata});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("stall_mem_v_o", {31'b0, mem_v_o}, 32'd1);
      chk("stall_mem_addr", {16'b0, mem_addr_o}, {16'b0, addr});
      chk("stall_mem_data", {24'b0, mem_data_o}, {24'b0, wdata});
      chk("stall_ready_o", {31'b0, ready_o}, 32'd0);
    end
    @(posedge clk_i); #1;
    mem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    mem_ready_i = 1'b0;
    if (!w) begin
      exp_q.push_back({24'b0, rdata});
      for (int i = 0; i < lat; i++) begin
        @(negedge clk_i);
        chk("wait_v_o", {31'b0, v_o}, 32'd0);
        chk("wait_mem_v_o", {31'b0, mem_v_o}, 32'd0);
        @(posedge clk_i); #1;
      end
      mem_v_i    = 1'b1;
      mem_data_i = rdata;
      @(posedge clk_i); #1;
      mem_v_i    = 1'b0;
      mem_data_i = 8'h00;
      @(negedge clk_i);
      chk("v_o_after_mem_v_i", {31'b0, v_o}, 32'd1);
      chk("data_o_after_mem_v_i", data_o, {24'b0, rdata});
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    reset_i = 1'b1; v_i = 1'b0; data_i = '0; ready_i = 1'b1;
    mem_ready_i = 1'b0; mem_v_i = 1'b0; mem_data_i = '0;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready_o", {31'b0, ready_o}, 32'd1);
    chk("rst_v_o", {31'b0, v_o}, 32'd0);
    chk("rst_mem_v_o", {31'b0, mem_v_o}, 32'd0);
    chk("rst_data_o", data_o, 32'd0);
    @(posedge clk_i); #1;

    // In-range write.
    send_cmd(32'h8000_12AB, 1'b1);
    serve_mem(1'b1, 16'h0012, 8'hAB, 8'h00, 0, 0);
`ifndef STORE_UNPACKER_WRITE_ACK_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("write_no_resp", {31'b0, v_o}, 32'd0);
    end
`endif
    drain();

    // Read with 3-cycle memory latency.
    send_cmd(32'h0000_1200, 1'b1);
    serve_mem(1'b0, 16'h0012, 8'h00, 8'hAB, 0, 3);
    drain();

    // Highest in-range address write.
    send_cmd(32'h80FF_FF11, 1'b1);
    serve_mem(1'b1, 16'hFFFF, 8'h11, 8'h00, 0, 0);
    drain();

    // Out-of-range read and write never reach memory.
    cnt0 = mem_hs_cnt;
    send_cmd(32'h0100_0000, 1'b0);
    drain();
    send_cmd(32'h8100_0055, 1'b0);
    drain();
    chk("oor_no_mem", 32'(mem_hs_cnt), 32'(cnt0));

    // Memory and response backpressure with a competing command held valid.
    cnt0 = mem_hs_cnt;
    ready_i = 1'b0;
    send_cmd(32'h0034_5600, 1'b1);
    @(posedge clk_i); #1;
    data_i = 32'h8000_0001;
    v_i    = 1'b1;
    serve_mem(1'b0, 16'h3456, 8'h00, 8'hC3, 4, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_v_o", {31'b0, v_o}, 32'd1);
      chk("bp_data_o", data_o, 32'h0000_00C3);
      chk("bp_ready_o", {31'b0, ready_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    v_i     = 1'b0;
    ready_i = 1'b1;
    drain();
    chk("bp_one_mem_hs", 32'(mem_hs_cnt - cnt0), 32'd1);

    // Reset while waiting for read data; the late data must be ignored.
    send_cmd(32'h0000_4400, 1'b1);
    @(posedge clk_i); #1;
    mem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    chk("wait_ready_o", {31'b0, ready_o}, 32'd0);
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i    = 1'b0;
    mem_v_i    = 1'b1;
    mem_data_i = 8'h5A;
    @(posedge clk_i); #1;
    mem_v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("post_rst_v_o", {31'b0, v_o}, 32'd0);
      chk("post_rst_ready_o", {31'b0, ready_o}, 32'd1);
    end

    chk("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
